// File: rtl/tcm_share_arbiter_pkg.sv
// Shared widths for the IFU/LSU single-port TCM arbiter.
// Byte address, data, byte-mask, word-address and counter widths.
package tcm_share_arbiter_pkg;

   localparam int TCM_AW    = 16;
   localparam int TCM_DW    = 32;
   localparam int TCM_MW    = TCM_DW / 8;
   localparam int TCM_WAW   = TCM_AW - 2;
   localparam int TCM_CNT_W = 8;

endpackage

// File: rtl/tcm_rsp_hold.sv
// Per-port response path: pending flag, 1-entry hold register, rdata mux.
// Ports: grant/grant_wr in, rsp_ready in, sram_dout in; free, rsp_valid/rdata out.
module tcm_rsp_hold
   import tcm_share_arbiter_pkg::*;
#(
   parameter int DW = TCM_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          grant,
   input  logic          grant_wr,
   input  logic          rsp_ready,
   input  logic [DW-1:0] sram_dout,
   output logic          free,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata
);

   logic          pend;
   logic          pend_wr;
   logic          hold_vld;
   logic [DW-1:0] hold_data;
   logic [DW-1:0] live_data;

   assign live_data = pend_wr ? '0 : sram_dout;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= 1'b0;
         pend_wr   <= 1'b0;
         hold_vld  <= 1'b0;
         hold_data <= '0;
      end else begin
         pend    <= grant;
         pend_wr <= grant & grant_wr;
         // SRAM data is only valid for one cycle: park it if not taken
         if (pend && !rsp_ready) begin
            hold_vld  <= 1'b1;
            hold_data <= live_data;
         end else if (rsp_ready) begin
            hold_vld  <= 1'b0;
         end
      end
   end

   assign free = !hold_vld && !(pend && !rsp_ready);

   // In-flight response is dropped while reset is asserted
   always_comb begin
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      if (!rst) begin
         rsp_valid = pend | hold_vld;
         if (hold_vld)  rsp_rdata = hold_data;
         else if (pend) rsp_rdata = live_data;
      end
   end

endmodule

// File: rtl/tcm_share_arbiter.sv
// Shares one single-port SRAM between IFU fetch and LSU data channels.
// LSU has fixed priority; IFU gets a grant after STARVE_MAX LSU wins.
module tcm_share_arbiter
   import tcm_share_arbiter_pkg::*;
#(
   parameter int AW         = TCM_AW,
   parameter int DW         = TCM_DW,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ifu_cmd_valid,
   output logic            ifu_cmd_ready,
   input  logic [AW-1:0]   ifu_cmd_addr,
   output logic            ifu_rsp_valid,
   input  logic            ifu_rsp_ready,
   output logic [DW-1:0]   ifu_rsp_rdata,
   input  logic            lsu_cmd_valid,
   output logic            lsu_cmd_ready,
   input  logic            lsu_cmd_read,
   input  logic [AW-1:0]   lsu_cmd_addr,
   input  logic [DW-1:0]   lsu_cmd_wdata,
   input  logic [DW/8-1:0] lsu_cmd_wmask,
   output logic            lsu_rsp_valid,
   input  logic            lsu_rsp_ready,
   output logic [DW-1:0]   lsu_rsp_rdata,
   output logic            sram_cs,
   output logic            sram_we,
   output logic [AW-3:0]   sram_addr,
   output logic [DW-1:0]   sram_wdata,
   output logic [DW/8-1:0] sram_wem,
   input  logic [DW-1:0]   sram_dout
);

   localparam logic [TCM_CNT_W-1:0] SMAX =
      TCM_CNT_W'(STARVE_MAX);

   logic                 ifu_free;
   logic                 lsu_free;
   logic                 ifu_want;
   logic                 lsu_want;
   logic                 starved;
   logic                 grant_ifu;
   logic                 grant_lsu;
   logic [TCM_CNT_W-1:0] starve_cnt;
   logic                 unused_ok;

   assign unused_ok = ^{ifu_cmd_addr[1:0], lsu_cmd_addr[1:0]};

   assign ifu_want  = ifu_cmd_valid & ifu_free;
   assign lsu_want  = lsu_cmd_valid & lsu_free;
   assign starved   = ifu_want & (starve_cnt == SMAX);
   assign grant_lsu = !rst & lsu_want & !starved;
   assign grant_ifu = !rst & ifu_want & !grant_lsu;

   assign ifu_cmd_ready = grant_ifu;
   assign lsu_cmd_ready = grant_lsu;
   assign sram_cs       = grant_ifu | grant_lsu;
   assign sram_we       = grant_lsu & !lsu_cmd_read;

   always_comb begin
      sram_addr  = '0;
      sram_wdata = '0;
      sram_wem   = '0;
      unique case (1'b1)
         grant_lsu: begin
            sram_addr  = lsu_cmd_addr[AW-1:2];
            sram_wdata = lsu_cmd_wdata;
            if (!lsu_cmd_read) sram_wem = lsu_cmd_wmask;
         end
         grant_ifu: begin
            sram_addr  = ifu_cmd_addr[AW-1:2];
         end
         default: ;
      endcase
   end

   // Counts LSU wins while the IFU is asking; saturates at SMAX
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_ifu) begin
         starve_cnt <= '0;
      end else if (grant_lsu && ifu_cmd_valid) begin
         if (starve_cnt != SMAX)
            starve_cnt <= starve_cnt + 1'b1;
      end else if (!ifu_cmd_valid) begin
         starve_cnt <= '0;
      end
   end

   tcm_rsp_hold #(.DW(DW)) u_ifu_rsp (
      .clk       (clk),
      .rst       (rst),
      .grant     (grant_ifu),
      .grant_wr  (1'b0),
      .rsp_ready (ifu_rsp_ready),
      .sram_dout (sram_dout),
      .free      (ifu_free),
      .rsp_valid (ifu_rsp_valid),
      .rsp_rdata (ifu_rsp_rdata)
   );

   tcm_rsp_hold #(.DW(DW)) u_lsu_rsp (
      .clk       (clk),
      .rst       (rst),
      .grant     (grant_lsu),
      .grant_wr  (!lsu_cmd_read),
      .rsp_ready (lsu_rsp_ready),
      .sram_dout (sram_dout),
      .free      (lsu_free),
      .rsp_valid (lsu_rsp_valid),
      .rsp_rdata (lsu_rsp_rdata)
   );

endmodule

// File: doc/tcm_share_arbiter.md
Name: tcm_share_arbiter

Overview:
- Lets the IFU fetch channel and the LSU data channel share one single-port SRAM, which replaces the separate ITCM and DTCM.
- Sits between the core's ifu2itcm/lsu2dtcm valid/ready interfaces and the SRAM macro.
- Arbitration is fixed-priority with LSU first, plus a starvation guard for the IFU.
- SRAM read latency is 1 cycle. Each port has a 1-entry response holding register so that response back-pressure never corrupts data.

Parameters:
- AW, 16, byte address width of both command ports.
- DW, 32, data width. The mask is DW/8 bits.
- STARVE_MAX, 4, number of consecutive LSU grants allowed while the IFU waits. The next grant then goes to the IFU. Range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ifu_cmd_valid  in  1  IFU fetch request
- ifu_cmd_ready  out  1  IFU request accepted
- ifu_cmd_addr  in  AW  IFU byte address
- ifu_rsp_valid  out  1  IFU read data valid
- ifu_rsp_ready  in  1  IFU accepts response
- ifu_rsp_rdata  out  DW  IFU read data
- lsu_cmd_valid  in  1  LSU request
- lsu_cmd_ready  out  1  LSU request accepted
- lsu_cmd_read  in  1  1 = read, 0 = write
- lsu_cmd_addr  in  AW  LSU byte address
- lsu_cmd_wdata  in  DW  write data
- lsu_cmd_wmask  in  DW/8  byte write enables
- lsu_rsp_valid  out  1  LSU response valid (reads and writes)
- lsu_rsp_ready  in  1  LSU accepts response
- lsu_rsp_rdata  out  DW  read data; 0 for write responses
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_addr  out  AW-2  word address, equal to cmd_addr[AW-1:2]
- sram_wdata  out  DW  SRAM write data
- sram_wem  out  DW/8  SRAM byte write mask
- sram_dout  in  DW  SRAM read data, valid in the cycle after a read cs

Behaviour:
- Reset: every output is 0. The pend_ifu/pend_lsu, hold_*_vld and starve_cnt registers are cleared. Reset dropping an in-flight access discards it; no response is issued after reset.
- Per-port state:
  - pend_p: set in the cycle after a grant to p; marks the response as live in that cycle.
  - hold_p_vld / hold_p_data: captured response.
  - pend_lsu_wr: the pending LSU access is a write.
- Port p is free when !hold_p_vld and !(pend_p & !p_rsp_ready).
- Grant for the LSU (grant_lsu) when:
  - lsu_cmd_valid and the LSU port is free, and
  - !(ifu_cmd_valid & ifu free & starve_cnt == STARVE_MAX).
- Grant for the IFU (grant_ifu) when ifu_cmd_valid, the IFU port is free and !grant_lsu. At most one grant per cycle.
- cmd_ready = grant for that port (combinational).
- SRAM drive:
  - sram_cs = grant_ifu | grant_lsu.
  - sram_we = grant_lsu & !lsu_cmd_read.
  - sram_wem = wmask on an LSU write, else 0.
  - sram_addr/sram_wdata are muxed from the granted port; they are 0 when idle.
- Response, per port:
  - p_rsp_valid = pend_p | hold_p_vld.
  - p_rsp_rdata = hold_p_vld ? hold_p_data : (pend_lsu_wr ? 0 : sram_dout).
  - If pend_p & !p_rsp_ready: the hold register captures the data in that cycle.
  - hold_p_vld clears on p_rsp_ready.
  - A response is never lost or duplicated.
- Latency: a grant in cycle t gives rsp_valid in t+1. A port with rsp_ready tied 1 sustains 1 access per cycle.
- starve_cnt, evaluated in priority order:
  - resets to 0 on grant_ifu;
  - otherwise increments (saturating at STARVE_MAX) on grant_lsu while ifu_cmd_valid;
  - otherwise is cleared when ifu_cmd_valid == 0.
- Simultaneous valid on both ports, starve_cnt < STARVE_MAX: the LSU wins.
- Simultaneous valid, but the LSU is blocked by back-pressure: the IFU wins, and starve_cnt is unchanged except that it resets to 0 on that IFU grant.
- A port that is blocked by its own back-pressure never stalls the other port.

Decomposition:
- Shared package: defines for AW, DW and mask width, plus localparams for the SRAM word-address width.
- Natural sub-module: tcm_rsp_hold. It is the per-port pend/hold/valid/rdata-mux logic, instantiated twice (IFU, LSU). The arbiter and starve counter stay in the top.

Test Plan:
- IFU streams reads of 0x0000, 0x0004 and 0x0008, rsp_ready=1, LSU idle:
  - cmd_ready high 3 consecutive cycles;
  - rsp_valid in cycles t+1..t+3;
  - rdata matches preloaded words 0x11111111 / 0x22222222 / 0x33333333.
- LSU write to 0x0010 (wdata 0xA5A5A5A5, wmask 4'b0011), then LSU read of 0x0010 over preload 0xFFFFFFFF:
  - write rsp_rdata = 0;
  - read returns 0xFFFFA5A5.
- Both valid continuously, STARVE_MAX=4: grant pattern is LSU ×4, IFU ×1, repeating. starve_cnt returns to 0 after each IFU grant.
- IFU rsp_ready held low 5 cycles after a read of 0x0004:
  - ifu_rsp_valid stays high with stable 0x22222222;
  - no new IFU grant during that time;
  - the LSU keeps being granted every cycle;
  - one response is delivered when ready rises.
- Assert rst in the cycle after an LSU read grant: no lsu_rsp_valid afterwards, every output is 0 in the following cycle, and normal operation resumes after rst is released.
- Random valid/ready on both ports against a reference memory model: every command yields exactly one response, in order per port, with data matching the model.
